uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_rx_os.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state encoding,
// oversample constants and the 2-of-3 majority voter.
package uart_pkg;

   localparam int OS_RATE = 16;

   localparam logic [3:0] SAMPLE_LO  = 4'd7;
   localparam logic [3:0] SAMPLE_MID = 4'd8;
   localparam logic [3:0] SAMPLE_HI  = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks. A synchronous
// clear restarts the period so the first tick lands DIV clocks after the clear.
module uart_baud_tick #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Down-counter: reload on clear or terminal count, otherwise decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || (cnt_q == '0)) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == '0) && !clr_i;

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver (8N1) with valid/ready output and
// frame-error / overrun pulses.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for synchronized rx to go low
//   ST_START | validating start bit; a high majority rejects it as a glitch
//   ST_DATA  | shifting in 8 data bits, LSB first
//   ST_STOP  | sampling stop bit; high delivers the byte, low is a frame error
//   ST_BREAK | line stuck low after a frame error, waiting for rx to rise
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLK_RATE  = 100000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   // Must be at least 1 for the chosen clock / baud pair.
   localparam int DIV = CLK_RATE / (BAUD_RATE * OS_RATE);

   state_t     state_q, state_d;
   logic       rx_meta_q, rx_sync_q;
   logic [3:0] os_cnt_q, os_cnt_d;
   logic [1:0] smp_q, smp_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       frame_err_q, frame_err_d;
   logic       overrun_q, overrun_d;

   logic       tick;
   logic       samp_tick, wrap_tick, bit_maj;
   logic       div_clr, bit_clr, bit_inc, shift_en, deliver, stop_bad;

   uart_baud_tick #(.DIV(DIV)) u_baud (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (div_clr),
      .tick_o (tick)
   );

   // Two-flop synchronizer on the asynchronous serial line, idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // The third vote is the live sample taken on the os_cnt=9 tick itself.
   assign samp_tick = tick && (os_cnt_q == SAMPLE_HI);
   assign wrap_tick = tick && (os_cnt_q == 4'(OS_RATE - 1));
   assign bit_maj   = maj3(smp_q[0], smp_q[1], rx_sync_q);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!rx_sync_q) state_d = ST_START;
         end
         ST_START: begin
            if (samp_tick && bit_maj) begin
               state_d = ST_IDLE;
            end else if (wrap_tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (wrap_tick && (bit_cnt_q == 3'd7)) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (samp_tick) state_d = bit_maj ? ST_IDLE : ST_BREAK;
         end
         ST_BREAK: begin
            if (rx_sync_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: datapath strobes decoded from the current state.
   always_comb begin
      div_clr  = 1'b0;
      bit_clr  = 1'b0;
      bit_inc  = 1'b0;
      shift_en = 1'b0;
      deliver  = 1'b0;
      stop_bad = 1'b0;
      case (state_q)
         ST_IDLE:  div_clr = !rx_sync_q;
         ST_START: bit_clr = 1'b1;
         ST_DATA: begin
            shift_en = samp_tick;
            bit_inc  = wrap_tick;
         end
         ST_STOP: begin
            deliver  = samp_tick && bit_maj;
            stop_bad = samp_tick && !bit_maj;
         end
         default: ;
      endcase
   end

   // Datapath next-state: oversample counter, vote samples, shifter, output handshake.
   always_comb begin
      os_cnt_d    = os_cnt_q;
      smp_d       = smp_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = 1'b0;
      frame_err_d = stop_bad;

      if (div_clr) begin
         os_cnt_d = 4'd0;
      end else if (tick) begin
         os_cnt_d = os_cnt_q + 4'd1;
      end

      if (tick && (os_cnt_q == SAMPLE_LO))  smp_d[0] = rx_sync_q;
      if (tick && (os_cnt_q == SAMPLE_MID)) smp_d[1] = rx_sync_q;

      if (bit_clr) begin
         bit_cnt_d = 3'd0;
      end else if (bit_inc) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      if (shift_en) shift_d = {bit_maj, shift_q[7:1]};

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

      // A pending unaccepted byte wins; a same-cycle handshake frees the slot.
      if (deliver) begin
         if (rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
         end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         os_cnt_q    <= 4'd0;
         smp_q       <= 2'b11;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         os_cnt_q    <= os_cnt_d;
         smp_q       <= smp_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
module tb_uart_rx_os;
   import uart_pkg::*;

   localparam int CLK_RATE  = 1600000;
   localparam int BAUD_RATE = 10000;
   localparam int BIT       = 160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun;

   int checks = 0;
   int errors = 0;

   int   cyc = 0;
   int   valid_cycles = 0;
   int   ferr_cnt = 0;
   int   ovr_cnt = 0;
   int   rise_cyc = -1;
   logic valid_prev = 1'b0;
   logic [7:0] got_q[$];

   uart_rx_os #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe the consumer side half a cycle away from the active edge.
   always @(negedge clk) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) valid_cycles = valid_cycles + 1;
      if (rx_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = rx_valid;
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (overrun) ovr_cnt = ovr_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Entered and left at posedge+1ns.
   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
      drive_bit(stop, BIT);
   endtask

   initial begin
      int v0, f0, o0, L, c0, base, nbad;
      logic [7:0] d_r;
      logic       good_r;
      logic       rand_done;
      logic [7:0] exp_q[$];

      // Reset values
      rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 8'h00);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst = 1'b0;
      drive_bit(1'b1, 50);

      // Clean 0xA5 with consumer always ready
      v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt; base = got_q.size();
      send_frame(8'hA5, 1'b1);
      drive_bit(1'b1, 100);
      check("a5_count", got_q.size(), base + 1);
      check("a5_data", got_q[$], 8'hA5);
      check("a5_valid_cycles", valid_cycles - v0, 1);
      check("a5_ferr", ferr_cnt - f0, 0);
      check("a5_ovr", ovr_cnt - o0, 0);

      // Short low glitch is rejected
      v0 = valid_cycles; f0 = ferr_cnt;
      drive_bit(1'b0, 30);
      drive_bit(1'b1, 300);
      check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("glitch_valid", valid_cycles - v0, 0);
      check("glitch_ferr", ferr_cnt - f0, 0);

      // Low stop bit followed by a held-low line
      v0 = valid_cycles; f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0);
      drive_bit(1'b0, 500);
      check("brk_ferr", ferr_cnt - f0, 1);
      check("brk_valid", valid_cycles - v0, 0);
      check("brk_state", 32'(dut.state_q), 32'(ST_BREAK));
      drive_bit(1'b1, 20);
      check("brk_exit", 32'(dut.state_q), 32'(ST_IDLE));
      drive_bit(1'b1, 100);

      // Back-to-back frames with consumer stalled: second byte overruns
      rx_ready = 1'b0;
      f0 = ferr_cnt; o0 = ovr_cnt;
      c0 = cyc;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      drive_bit(1'b1, 200);
      L = rise_cyc - c0;
      check("lat_window", (L >= 1530 && L <= 1560), 1);
      if (L < 1530 || L > 1560) L = 1543;
      check("ovr_valid", rx_valid, 1);
      check("ovr_data_kept", rx_data, 8'h11);
      check("ovr_pulses", ovr_cnt - o0, 1);
      check("ovr_ferr", ferr_cnt - f0, 0);
      base = got_q.size();
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      check("drain_valid", rx_valid, 0);
      check("drain_count", got_q.size(), base + 1);
      check("drain_data", got_q[$], 8'h11);

      // Handshake in the very cycle the next byte is delivered
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b1);
      base = got_q.size();
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (L - 1) @(posedge clk);
            #1;
            rx_ready = 1'b1;
            @(posedge clk);
            #1;
            rx_ready = 1'b0;
         end
      join
      drive_bit(1'b1, 100);
      check("same_valid", rx_valid, 1);
      check("same_data", rx_data, 8'h22);
      check("same_ovr", ovr_cnt - o0, 0);
      check("same_count", got_q.size(), base + 1);
      check("same_accepted", got_q[$], 8'h11);

      // Reset in the middle of a frame, then a clean 0x5A
      f0 = ferr_cnt;
      for (int i = 0; i < 5; i++) drive_bit(1'b0, BIT);
      drive_bit(1'b1, 80);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", rx_valid, 0);
      check("mid_rst_data", rx_data, 8'h00);
      check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("mid_rst_ovr", overrun, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      drive_bit(1'b1, 400);
      check("post_rst_valid", rx_valid, 0);
      check("post_rst_ferr", ferr_cnt - f0, 0);
      rx_ready = 1'b1;
      base = got_q.size();
      send_frame(8'h5A, 1'b1);
      drive_bit(1'b1, 100);
      check("5a_count", got_q.size(), base + 1);
      check("5a_data", got_q[$], 8'h5A);
      check("5a_rx_data", rx_data, 8'h5A);

      // Random bytes, random stop-bit faults and a randomly stalling consumer
      base = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt; nbad = 0;
      rand_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 12; n++) begin
               d_r    = 8'($urandom);
               good_r = ($urandom_range(0, 3) != 0);
               send_frame(d_r, good_r);
               if (good_r) begin
                  exp_q.push_back(d_r);
                  drive_bit(1'b1, int'($urandom_range(1, 100)));
               end else begin
                  nbad++;
                  drive_bit(1'b0, int'($urandom_range(1, 200)));
                  drive_bit(1'b1, int'($urandom_range(20, 200)));
               end
            end
            drive_bit(1'b1, 50);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               rx_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      rx_ready = 1'b1;
      drive_bit(1'b1, 20);
      check("rnd_count", got_q.size(), base + exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("rnd_byte%0d", i), got_q[base + i], exp_q[i]);
      end
      check("rnd_ferr", ferr_cnt - f0, nbad);
      check("rnd_ovr", ovr_cnt - o0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
